// File: rtl/microwave_ctrl_if.sv
// Panel and datapath signals of the microwave controller.
// The optional beep line exists only when DONE_BEEP_EN is defined.
interface microwave_ctrl_if;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;
  logic       time_zero;
  logic       digit_load;
  logic [3:0] digit_val;
  logic       clear_time;
  logic       dec_tick;
  logic       mag_on;
  logic [2:0] state;
`ifdef DONE_BEEP_EN
  logic       beep;
`endif

  // master = the controller, slave = panel/datapath side
  modport master (
    input  keypad, startn, stopn, clearn, door_closed, time_zero,
    output digit_load, digit_val, clear_time, dec_tick, mag_on, state
`ifdef DONE_BEEP_EN
    , output beep
`endif
  );

  modport slave (
    output keypad, startn, stopn, clearn, door_closed, time_zero,
    input  digit_load, digit_val, clear_time, dec_tick, mag_on, state
`ifdef DONE_BEEP_EN
    , input beep
`endif
  );
endinterface

// File: rtl/microwave_ctrl.sv
// Microwave sequencing FSM: synchronises panel inputs, issues digit/clear/tick strobes, drives mag_on.
// Optional DONE_BEEP_EN adds a beep output held for BEEP_TICKS prescaler wraps after cooking ends.
//
// state | meaning
// IDLE  | no time entered, waiting for first digit
// ENTRY | collecting up to three digits
// COOK  | magnetron on, prescaler issuing 1 s ticks
// PAUSE | door opened or stop pressed, prescaler held
// DONE  | time expired, waiting for key/start to acknowledge
module microwave_ctrl #(
  parameter int TICK_DIV   = 100,
  parameter int BEEP_TICKS = 3
) (
  input logic              clock,
  input logic              resetn,
  microwave_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  // bit map: [9:0] keypad, [10] startn, [11] stopn, [12] clearn, [13] door_closed
  localparam logic [13:0] SYNC_RST = {1'b0, 3'b111, 10'b0};

  state_t        state_q, state_d;
  logic [13:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    btn_prev_q, btn_prev_d;
  logic          key_prev_q, key_prev_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          load_q, load_d;
  logic [3:0]    val_q, val_d;
  logic          clr_q, clr_d;
  logic          tick_q, tick_d;
  logic          mag_q, mag_d;

  logic [9:0] kp;
  logic [3:0] kp_idx;
  logic       key_ev, start_ev, stop_ev, clear_ev, door_open, start_ok, pre_wrap;

  assign kp        = sync2_q[9:0];
  assign key_ev    = (|kp) & ~key_prev_q & $onehot(kp);
  assign start_ev  = btn_prev_q[0] & ~sync2_q[10];
  assign stop_ev   = btn_prev_q[1] & ~sync2_q[11];
  assign clear_ev  = btn_prev_q[2] & ~sync2_q[12];
  assign door_open = ~sync2_q[13];
  assign start_ok  = start_ev & ~door_open & ~bus.time_zero;
  assign pre_wrap  = (pre_q == PRE_MAX);

  always_comb begin
    kp_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (kp[i]) kp_idx = 4'(i);
    end
  end

  always_comb begin
    sync1_d    = {bus.door_closed, bus.clearn, bus.stopn, bus.startn, bus.keypad};
    sync2_d    = sync1_q;
    btn_prev_d = sync2_q[12:10];
    key_prev_d = |kp;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (key_ev) state_d = S_ENTRY;
        S_ENTRY: if (start_ok) state_d = S_COOK;
        S_COOK: begin
          // expiry beats a tick landing in the same cycle
          if (bus.time_zero)            state_d = S_DONE;
          else if (door_open || stop_ev) state_d = S_PAUSE;
        end
        S_PAUSE: if (start_ok) state_d = S_COOK;
        S_DONE:  if (key_ev || start_ev) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    load_d = key_ev & ~clear_ev &
             ((state_q == S_IDLE) |
              ((state_q == S_ENTRY) & (state_d == S_ENTRY) & (cnt_q != 2'd3)));
    val_d  = load_d ? kp_idx : 4'd0;
    clr_d  = clear_ev | ((state_q == S_DONE) & (state_d == S_IDLE));
    mag_d  = (state_d == S_COOK);

    cnt_d = cnt_q;
    if (clr_d)       cnt_d = 2'd0;
    else if (load_d) cnt_d = (state_q == S_IDLE) ? 2'd1 : cnt_q + 2'd1;

    // PAUSE keeps pre_q so a resumed cook finishes the partial second
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (clear_ev || ((state_q == S_ENTRY) && (state_d == S_COOK))) begin
      pre_d = '0;
    end else if ((state_q == S_COOK) && (state_d == S_COOK)) begin
      pre_d  = pre_wrap ? '0 : pre_q + 1'b1;
      tick_d = pre_wrap;
`ifdef DONE_BEEP_EN
    end else if ((state_q != S_DONE) && (state_d == S_DONE)) begin
      pre_d = '0;
    end else if ((state_q == S_DONE) && (state_d == S_DONE)) begin
      pre_d = pre_wrap ? '0 : pre_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= SYNC_RST;
      sync2_q    <= SYNC_RST;
      btn_prev_q <= 3'b111;
      key_prev_q <= 1'b0;
      cnt_q      <= 2'd0;
      pre_q      <= '0;
      load_q     <= 1'b0;
      val_q      <= 4'd0;
      clr_q      <= 1'b0;
      tick_q     <= 1'b0;
      mag_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_prev_q <= btn_prev_d;
      key_prev_q <= key_prev_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      load_q     <= load_d;
      val_q      <= val_d;
      clr_q      <= clr_d;
      tick_q     <= tick_d;
      mag_q      <= mag_d;
    end
  end

`ifdef DONE_BEEP_EN
  localparam int BW = $clog2(BEEP_TICKS + 1);

  logic          beep_q, beep_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    beep_d = beep_q;
    bcnt_d = bcnt_q;
    if (state_d != S_DONE) begin
      beep_d = 1'b0;
      bcnt_d = '0;
    end else if (state_q != S_DONE) begin
      beep_d = 1'b1;
      bcnt_d = '0;
    end else if (beep_q && pre_wrap) begin
      bcnt_d = bcnt_q + 1'b1;
      if (bcnt_d == BW'(BEEP_TICKS)) beep_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      beep_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      beep_q <= beep_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign bus.beep = beep_q;
`endif

  assign bus.digit_load = load_q;
  assign bus.digit_val  = val_q;
  assign bus.clear_time = clr_q;
  assign bus.dec_tick   = tick_q;
  assign bus.mag_on     = mag_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_microwave_ctrl.sv
// Scoreboard bench for microwave_ctrl with TICK_DIV=4 and a small time-register model as datapath.
module tb_microwave_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int BEEP_TICKS = 3;

  typedef struct { int kind; int val; int at; } ev_t;   // kind: 0 digit, 1 clear, 2 tick
  typedef struct { int at; int st; int mag; int chk_beep; int beep; } st_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   rem    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done      = 1'b0;
  bit   rst_probe = 1'b0;
  ev_t  ev_q[$];
  st_t  st_q[$];

  microwave_ctrl_if bus();

  microwave_ctrl #(.TICK_DIV(TICK_DIV), .BEEP_TICKS(BEEP_TICKS)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // datapath stand-in: decimal seconds register
  always @(posedge clock) begin
    if (bus.clear_time === 1'b1)      rem <= 0;
    else if (bus.digit_load === 1'b1) rem <= rem * 10 + int'(bus.digit_val);
    else if (bus.dec_tick === 1'b1 && rem > 0) rem <= rem - 1;
  end
  assign bus.time_zero = (rem == 0);

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic strobe(int kind, int val);
    ev_t e;
    if (ev_q.size() == 0) begin
      check("unexpected_strobe_kind", kind, -1);
      return;
    end
    e = ev_q.pop_front();
    check("strobe_kind", kind, e.kind);
    check("strobe_cycle", cyc, e.at);
    if (kind == 0) check("digit_val", val, e.val);
  endtask

  always @(negedge clock or negedge resetn) begin
    st_t s;
    if (rst_probe) begin
      #1;
      check("async_rst_mag_on", int'(bus.mag_on), 0);
      check("async_rst_state", int'(bus.state), 0);
    end else begin
      if (bus.digit_load === 1'b1) strobe(0, int'(bus.digit_val));
      if (bus.clear_time === 1'b1) strobe(1, 0);
      if (bus.dec_tick === 1'b1)   strobe(2, 0);
      while (st_q.size() > 0 && st_q[0].at <= cyc) begin
        s = st_q.pop_front();
        check("state_cycle", cyc, s.at);
        check("state", int'(bus.state), s.st);
        check("mag_on", int'(bus.mag_on), s.mag);
`ifdef DONE_BEEP_EN
        if (s.chk_beep != 0) check("beep", int'(bus.beep), s.beep);
`endif
      end
      if (done) begin
        check("pending_events", ev_q.size(), 0);
        check("pending_state_checks", st_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  function automatic void exp_ev(int k, int v, int at);
    ev_q.push_back('{kind: k, val: v, at: at});
  endfunction

  function automatic void exp_st(int at, int st, int mag, int chk_beep = 0, int beep = 0);
    st_q.push_back('{at: at, st: st, mag: mag, chk_beep: chk_beep, beep: beep});
  endfunction

  task automatic at_cyc(int t);
    while (cyc < t) @(negedge clock);
  endtask

  // kind_exp: -1 no strobe, 0 digit_load of d, 1 clear_time
  task automatic key_stroke(logic [9:0] pat, int d, int kind_exp);
    int p;
    p = cyc;
    bus.keypad = pat;
    if (kind_exp >= 0) exp_ev(kind_exp, (kind_exp == 0) ? d : 0, p + 3);
    at_cyc(p + 4);
    bus.keypad = '0;
    at_cyc(p + 8);
  endtask

  task automatic btn_set(int b, logic lvl);
    case (b)
      0:       bus.startn = lvl;
      1:       bus.stopn  = lvl;
      default: bus.clearn = lvl;
    endcase
  endtask

  task automatic btn_down(int b, output int p);
    p = cyc;
    btn_set(b, 1'b0);
  endtask

  task automatic btn_up(int b);
    repeat (3) @(negedge clock);
    btn_set(b, 1'b1);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual cycle %0d required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, e, d, r, s, r2, c, dn;
    bus.keypad      = '0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.clearn      = 1'b1;
    bus.door_closed = 1'b0;

    exp_st(2, 0, 0, 1, 0);
    at_cyc(3);
    resetn = 1'b1;
    exp_st(5, 0, 0, 1, 0);
    at_cyc(6);

    // three digits accepted, fourth ignored
    key_stroke(10'b0000001000, 3, 0);
    key_stroke(10'b0000100000, 5, 0);
    key_stroke(10'b1000000000, 9, 0);
    exp_st(cyc + 1, 1, 0);
    key_stroke(10'b0000000010, 1, -1);
    exp_st(cyc + 1, 1, 0);
    at_cyc(cyc + 1);

    // start with door open is ignored
    btn_down(0, p);
    exp_st(p + 3, 1, 0);
    exp_st(p + 6, 1, 0);
    btn_up(0);

    // door closed, start: tick every 4 cycles
    bus.door_closed = 1'b1;
    at_cyc(cyc + 4);
    btn_down(0, p);
    e = p + 3;
    exp_st(e, 2, 1);
    exp_ev(2, 0, e + 4);
    exp_ev(2, 0, e + 8);
    btn_up(0);
    at_cyc(e + 8);

    // door opens with prescaler heading to 2: mag_on low on third edge
    bus.door_closed = 1'b0;
    d = cyc;
    exp_st(d + 2, 2, 1);
    exp_st(d + 3, 3, 0);
    at_cyc(d + 8);

    // resume: held prescaler 2 gives a tick two cycles in
    bus.door_closed = 1'b1;
    at_cyc(cyc + 4);
    btn_down(0, p);
    r = p + 3;
    exp_st(r, 2, 1);
    exp_ev(2, 0, r + 2);
    btn_up(0);

    // stop lands on the would-be tick cycle: PAUSE, no tick, prescaler held at 3
    btn_down(1, s);
    exp_st(s + 3, 3, 0);
    btn_up(1);
    at_cyc(s + 10);
    btn_down(0, p);
    r2 = p + 3;
    exp_st(r2, 2, 1);
    exp_ev(2, 0, r2 + 1);
    btn_up(0);

    // clear while cooking: one more tick before the clear lands
    btn_down(2, c);
    exp_ev(2, 0, c + 2);
    exp_ev(1, 0, c + 3);
    exp_st(c + 3, 0, 0);
    exp_st(c + 4, 0, 0);
    btn_up(2);

    // multi-hot keypad ignored
    key_stroke(10'b0000100100, 0, -1);
    exp_st(cyc + 1, 0, 0);
    at_cyc(cyc + 1);

    // 5 s cook to DONE
    key_stroke(10'b0000100000, 5, 0);
    btn_down(0, p);
    e = p + 3;
    exp_st(e, 2, 1);
    for (int k = 1; k <= 5; k++) exp_ev(2, 0, e + 4 * k);
    exp_st(e + 21, 2, 1);
    dn = e + 22;
    exp_st(dn, 4, 0, 1, 1);
    exp_st(dn + 11, 4, 0, 1, 1);
    exp_st(dn + 12, 4, 0, 1, 0);
    btn_up(0);
    at_cyc(dn + 14);

    // key in DONE acknowledges with clear_time
    key_stroke(10'b0000000100, 2, 1);
    exp_st(cyc + 1, 0, 0);
    at_cyc(cyc + 1);

    // reset asserted mid-cook
    key_stroke(10'b0010000000, 7, 0);
    btn_down(0, p);
    e = p + 3;
    exp_st(e, 2, 1);
    btn_up(0);
    #2;
    rst_probe = 1'b1;
    resetn    = 1'b0;
    #2;
    rst_probe = 1'b0;
    at_cyc(cyc + 2);
    exp_st(cyc + 1, 0, 0, 1, 0);
    at_cyc(cyc + 2);
    resetn = 1'b1;
    exp_st(cyc + 2, 0, 0, 1, 0);
    at_cyc(cyc + 4);
    done = 1'b1;
  end
endmodule
